// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        LEN,
        PAYLOAD,
        CHK
    } state_e;

    localparam logic [7:0] SYNC0_DEFAULT = 8'h55;
    localparam logic [7:0] SYNC1_DEFAULT = 8'hAA;

    // System clocks per UART bit.
    function automatic int unsigned bit_period(input int unsigned clk_freq,
                                               input int unsigned tx_freq);
        return clk_freq / tx_freq;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_parser_gap_timer.sv
// Inter-byte gap timer: reloads on each accepted byte, counts down while
// mid-frame, and pulses expire in the cycle the gap budget runs out.
module uart_gap_timer #(
    parameter int unsigned CYCLES = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load wins over expiry, so a byte arriving on the last cycle is kept.
    always_comb begin
        cnt_d      = cnt_q;
        o_expire_c = 1'b0;
        if (i_load) begin
            cnt_d = CNT_W'(CYCLES);
        end else if (!i_en) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d      = cnt_q - CNT_W'(1);
            o_expire_c = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts SYNC0/SYNC1/LEN/payload/CHK frames in a UART byte stream and streams
// payload bytes out, marking the final byte with last/err; counts frames.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned TX_FREQ       = 9600,
    parameter int unsigned MAX_LEN       = 64,
    parameter logic [7:0]  SYNC0         = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1         = SYNC1_DEFAULT,
    parameter int unsigned TIMEOUT_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vld,
    input  logic [7:0]  i_data,
    input  logic        i_pc_pass,
    output logic        o_rdy,
    output logic        o_vld,
    output logic [7:0]  o_data,
    output logic        o_last,
    output logic        o_err,
    input  logic        i_rdy,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_err
);

    localparam int unsigned TIMEOUT_CYC = TIMEOUT_BYTES * 10 * bit_period(CLK_FREQ, TX_FREQ);

    if (MAX_LEN == 0 || MAX_LEN > 255) begin : g_bad_max_len
        $error("uart_frame_parser: MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_BYTES == 0) begin : g_bad_timeout
        $error("uart_frame_parser: TIMEOUT_BYTES must be >= 1");
    end
    if (bit_period(CLK_FREQ, TX_FREQ) <= 4) begin : g_bad_ratio
        $error("uart_frame_parser: CLK_FREQ/TX_FREQ must exceed 4");
    end

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        flush_q, flush_d;
    logic        o_vld_q, o_vld_d;
    logic [7:0]  o_data_q, o_data_d;
    logic        o_last_q, o_last_d;
    logic        o_err_q, o_err_d;
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_err_q, frames_err_d;

    logic slot_free;
    logic accept;
    logic mid_frame;
    logic expire_c;
    logic abort;
    logic emit;
    logic emit_last;
    logic emit_err;

    assign slot_free = !o_vld_q || i_rdy;
    assign o_rdy     = slot_free && !flush_q;
    assign accept    = i_vld && o_rdy;
    assign mid_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);

    uart_gap_timer #(
        .CYCLES (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (accept),
        .i_en       (mid_frame),
        .o_expire_c (expire_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        flush_d      = flush_q;
        o_vld_d      = o_vld_q;
        o_data_d     = o_data_q;
        o_last_d     = o_last_q;
        o_err_d      = o_err_q;
        frames_ok_d  = frames_ok_q;
        frames_err_d = frames_err_q;
        abort        = 1'b0;
        emit         = 1'b0;
        emit_last    = 1'b0;
        emit_err     = 1'b0;

        if (o_vld_q && i_rdy) begin
            o_vld_d = 1'b0;
        end

        // Deferred abort: the held byte waits for the output slot to drain.
        if (flush_q && slot_free) begin
            emit       = 1'b1;
            emit_last  = 1'b1;
            emit_err   = 1'b1;
            hold_vld_d = 1'b0;
            flush_d    = 1'b0;
        end

        if (accept) begin
            case (state_q)
                HUNT0: begin
                    if (i_pc_pass && i_data == SYNC0) begin
                        state_d = HUNT1;
                    end
                end
                HUNT1: begin
                    if (!i_pc_pass) begin
                        state_d = HUNT0;
                    end else if (i_data == SYNC1) begin
                        state_d = LEN;
                    end else if (i_data == SYNC0) begin
                        state_d = HUNT1;
                    end else begin
                        state_d = HUNT0;
                    end
                end
                LEN: begin
                    if (!i_pc_pass) begin
                        abort = 1'b1;
                    end else if (i_data != 8'd0 && i_data <= 8'(MAX_LEN)) begin
                        cnt_d   = i_data;
                        sum_d   = i_data;
                        state_d = PAYLOAD;
                    end else begin
                        frames_err_d = sat_inc16(frames_err_q);
                        state_d      = HUNT0;
                    end
                end
                PAYLOAD: begin
                    if (!i_pc_pass) begin
                        abort = 1'b1;
                    end else begin
                        sum_d = sum_q + i_data;
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = CHK;
                        end
                        emit       = hold_vld_q;
                        hold_d     = i_data;
                        hold_vld_d = 1'b1;
                    end
                end
                CHK: begin
                    if (!i_pc_pass) begin
                        abort = 1'b1;
                    end else begin
                        emit       = 1'b1;
                        emit_last  = 1'b1;
                        emit_err   = (i_data != sum_q);
                        hold_vld_d = 1'b0;
                        state_d    = HUNT0;
                        if (i_data != sum_q) begin
                            frames_err_d = sat_inc16(frames_err_q);
                        end else begin
                            frames_ok_d = sat_inc16(frames_ok_q);
                        end
                    end
                end
                default: state_d = HUNT0;
            endcase
        end else if (expire_c) begin
            abort = 1'b1;
        end

        if (abort) begin
            frames_err_d = sat_inc16(frames_err_q);
            state_d      = HUNT0;
            if (hold_vld_q) begin
                if (slot_free) begin
                    emit       = 1'b1;
                    emit_last  = 1'b1;
                    emit_err   = 1'b1;
                    hold_vld_d = 1'b0;
                end else begin
                    flush_d = 1'b1;
                end
            end
        end

        if (emit) begin
            o_vld_d  = 1'b1;
            o_data_d = hold_q;
            o_last_d = emit_last;
            o_err_d  = emit_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT0;
            cnt_q        <= 8'd0;
            sum_q        <= 8'd0;
            hold_q       <= 8'd0;
            hold_vld_q   <= 1'b0;
            flush_q      <= 1'b0;
            o_vld_q      <= 1'b0;
            o_data_q     <= 8'd0;
            o_last_q     <= 1'b0;
            o_err_q      <= 1'b0;
            frames_ok_q  <= 16'd0;
            frames_err_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            flush_q      <= flush_d;
            o_vld_q      <= o_vld_d;
            o_data_q     <= o_data_d;
            o_last_q     <= o_last_d;
            o_err_q      <= o_err_d;
            frames_ok_q  <= frames_ok_d;
            frames_err_q <= frames_err_d;
        end
    end

    assign o_vld      = o_vld_q;
    assign o_data     = o_data_q;
    assign o_last     = o_last_q;
    assign o_err      = o_err_q;
    assign frames_ok  = frames_ok_q;
    assign frames_err = frames_err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: frame-level reference model feeds an
// expected queue; a negedge monitor checks every payload transfer.
module tb_uart_frame_parser;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned TX_FREQ  = 100;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned TO_BYTES = 3;
    localparam int unsigned TO_CYC   = TO_BYTES * 10 * (CLK_FREQ / TX_FREQ);
    localparam logic [7:0]  S0       = 8'h55;
    localparam logic [7:0]  S1       = 8'hAA;

    localparam int K_GOOD    = 0;
    localparam int K_BADCHK  = 1;
    localparam int K_BADLEN  = 2;
    localparam int K_PARITY  = 3;
    localparam int K_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vld = 1'b0;
    logic [7:0]  i_data = 8'd0;
    logic        i_pc_pass = 1'b1;
    logic        o_rdy;
    logic        o_vld;
    logic [7:0]  o_data;
    logic        o_last;
    logic        o_err;
    logic        i_rdy = 1'b1;
    logic [15:0] frames_ok;
    logic [15:0] frames_err;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ok_m  = 0;
    int   err_m = 0;
    bit   bp_random = 1'b0;
    bit   arm_stall = 1'b0;
    int   stall_left = 0;

    uart_frame_parser #(
        .CLK_FREQ      (CLK_FREQ),
        .TX_FREQ       (TX_FREQ),
        .MAX_LEN       (MAX_LEN),
        .SYNC0         (S0),
        .SYNC1         (S1),
        .TIMEOUT_BYTES (TO_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_vld      (i_vld),
        .i_data     (i_data),
        .i_pc_pass  (i_pc_pass),
        .o_rdy      (o_rdy),
        .o_vld      (o_vld),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_err      (o_err),
        .i_rdy      (i_rdy),
        .frames_ok  (frames_ok),
        .frames_err (frames_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic last, input logic err);
        exp_t e;
        e.data = d;
        e.last = last;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Reference: the first n payload bytes leave in order; only the last is marked.
    task automatic expect_bytes(input logic [7:0] p[$], input int n, input logic err);
        for (int i = 0; i < n; i++) begin
            push_exp(p[i], (i == n - 1), (i == n - 1) ? err : 1'b0);
        end
    endtask

    // Consumer: optional random back-pressure plus a one-shot 20-cycle stall.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            i_rdy = 1'b0;
            stall_left--;
        end else if (arm_stall && o_vld) begin
            i_rdy      = 1'b0;
            stall_left = 19;
            arm_stall  = 1'b0;
        end else if (bp_random) begin
            i_rdy = ($urandom_range(0, 3) != 0);
        end else begin
            i_rdy = 1'b1;
        end
    end

    // Monitor: one scoreboard pop per output transfer; o_rdy must drop while stalled.
    always @(negedge clk) begin
        if (!rst && o_vld) begin
            if (!i_rdy) begin
                check("stall_o_rdy", 32'(o_rdy), 32'd0);
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got data %0h last %0b, required no output",
                         o_data, o_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(o_data), 32'(e.data));
                check("out_last", 32'(o_last), 32'(e.last));
                if (e.last) begin
                    check("out_err", 32'(o_err), 32'(e.err));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic pass);
        int w;
        w = 0;
        i_vld     = 1'b1;
        i_data    = d;
        i_pc_pass = pass;
        @(negedge clk);
        while (!o_rdy && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: o_rdy low for %0d cycles, required high", w);
        end
        @(posedge clk);
        #1;
        i_vld     = 1'b0;
        i_pc_pass = 1'b1;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_vld) && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_%s: %0d outputs outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        idle(2);
        check({tag, "_frames_ok"}, 32'(frames_ok), 32'(ok_m));
        check({tag, "_frames_err"}, 32'(frames_err), 32'(err_m));
    endtask

    // Random frame: kind picks the outcome, cut picks where parity/timeout strikes.
    task automatic run_frame(input int kind, input int len, input int cut);
        logic [7:0] p[$];
        logic [7:0] chk;
        int         sum;
        sum = len;
        for (int i = 0; i < len && kind != K_BADLEN; i++) begin
            p.push_back(8'($urandom));
            sum += int'(p[i]);
        end
        chk = 8'(sum % 256);
        repeat ($urandom_range(0, 2)) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (g == S0) g = 8'h00;
            send_byte(g, 1'($urandom));
        end
        send_byte(S0, 1'b1);
        send_byte(S1, 1'b1);
        case (kind)
            K_GOOD, K_BADCHK: begin
                expect_bytes(p, len, kind == K_BADCHK);
                if (kind == K_BADCHK) err_m++; else ok_m++;
                send_byte(8'(len), 1'b1);
                for (int i = 0; i < len; i++) send_byte(p[i], 1'b1);
                send_byte((kind == K_BADCHK) ? chk + 8'($urandom_range(1, 255)) : chk, 1'b1);
            end
            K_BADLEN: begin
                err_m++;
                send_byte(8'(len), 1'b1);
            end
            K_PARITY: begin
                err_m++;
                if (cut < 0) begin
                    send_byte(8'(len), 1'b0);
                end else begin
                    expect_bytes(p, cut, 1'b1);
                    send_byte(8'(len), 1'b1);
                    for (int i = 0; i < cut; i++) send_byte(p[i], 1'b1);
                    send_byte((cut < len) ? p[cut] : chk, 1'b0);
                end
            end
            default: begin
                err_m++;
                expect_bytes(p, cut, 1'b1);
                send_byte(8'(len), 1'b1);
                for (int i = 0; i < cut; i++) send_byte(p[i], 1'b1);
                idle(TO_CYC + 10);
            end
        endcase
        drain($sformatf("rnd_k%0d", kind));
    endtask

    initial begin
        idle(4);
        rst = 1'b0;
        @(negedge clk);
        check("rst_o_vld", 32'(o_vld), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        check("rst_o_err", 32'(o_err), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_rdy", 32'(o_rdy), 32'd1);
        check("rst_frames_ok", 32'(frames_ok), 32'd0);
        check("rst_frames_err", 32'(frames_err), 32'd0);
        idle(1);

        // Good frame.
        push_exp(8'h11, 1'b0, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0);
        push_exp(8'h33, 1'b1, 1'b0);
        ok_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h03, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h69, 1);
        drain("good");

        // Bad checksum.
        push_exp(8'h10, 1'b0, 1'b0);
        push_exp(8'h20, 1'b1, 1'b1);
        err_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h02, 1);
        send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h00, 1);
        drain("badchk");

        // Resync through repeated SYNC0, then zero length.
        err_m++;
        send_byte(8'h00, 1); send_byte(8'h55, 1); send_byte(8'h55, 1);
        send_byte(8'hAA, 1); send_byte(8'h00, 1);
        drain("badlen0");
        push_exp(8'h7E, 1'b1, 1'b0);
        ok_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1);
        send_byte(8'h7E, 1); send_byte(8'h7F, 1);
        drain("len1");

        // Parity failure mid-payload, then a clean frame.
        push_exp(8'h01, 1'b0, 1'b0);
        push_exp(8'h02, 1'b1, 1'b1);
        err_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h04, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 0);
        drain("parity");
        run_frame(K_GOOD, 5, 0);

        // Timeout, then a late byte that must be ignored.
        push_exp(8'hA1, 1'b0, 1'b0);
        push_exp(8'hA2, 1'b1, 1'b1);
        err_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h04, 1);
        send_byte(8'hA1, 1); send_byte(8'hA2, 1);
        idle(TO_CYC + 5);
        send_byte(8'hA3, 1);
        drain("timeout");

        // Length boundaries.
        run_frame(K_GOOD, MAX_LEN, 0);
        run_frame(K_BADLEN, MAX_LEN + 1, 0);

        // Consumer stall of 20 cycles on the first output.
        arm_stall = 1'b1;
        push_exp(8'h01, 1'b0, 1'b0);
        push_exp(8'h02, 1'b0, 1'b0);
        push_exp(8'h03, 1'b1, 1'b0);
        ok_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h03, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h09, 1);
        drain("stall");

        // Randomised frames under random back-pressure.
        bp_random = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, MAX_LEN);
            if (kind == K_BADLEN) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                run_frame(kind, len, 0);
            end else if (kind == K_PARITY) begin
                run_frame(kind, len, $urandom_range(0, len + 1) - 1);
            end else begin
                run_frame(kind, len, $urandom_range(0, len));
            end
        end
        bp_random = 1'b0;
        idle(2);

        // Reset mid-frame discards the held byte.
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
        rst = 1'b1;
        idle(2);
        rst   = 1'b0;
        ok_m  = 0;
        err_m = 0;
        idle(5);
        check("midrst_o_vld", 32'(o_vld), 32'd0);
        push_exp(8'h7E, 1'b1, 1'b0);
        ok_m++;
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h01, 1);
        send_byte(8'h7E, 1); send_byte(8'h7F, 1);
        drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART receiver. Consumes its byte stream (valid/ready plus per-byte parity-pass flag) and hunts for framed packets. Streams payload bytes to the consumer with last/error marking on the final byte, and keeps saturating good/bad frame counters. Frame on the wire: SYNC0, SYNC1, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload) mod 256.

Parameters:
CLK_FREQ, 50000000, system clock in Hz
TX_FREQ, 9600, UART baud rate
MAX_LEN, 64, largest legal LEN value (1..255)
SYNC0, 8'h55, first sync byte
SYNC1, 8'hAA, second sync byte
TIMEOUT_BYTES, 3, inter-byte gap, in character times, that aborts a frame in progress

Ports:
clk  input  1  system clock; one clock domain; all logic on posedge clk
rst  input  1  synchronous, active-high reset
i_vld  input  1  byte valid from UART receiver
i_data  input  8  received byte
i_pc_pass  input  1  parity-check pass for i_data; qualified by i_vld
o_rdy  output  1  ready to UART receiver; transfer when i_vld && o_rdy
o_vld  output  1  payload byte valid to consumer
o_data  output  8  payload byte
o_last  output  1  final byte of the frame; qualified by o_vld
o_err  output  1  frame bad (checksum, parity or timeout); valid only when o_vld && o_last
i_rdy  input  1  consumer ready; transfer when o_vld && i_rdy
frames_ok  output  16  count of good frames, saturating at 16'hFFFF
frames_err  output  16  count of bad frames, saturating at 16'hFFFF

Behaviour:
- Reset: state=HUNT0; o_vld=0, o_last=0, o_err=0, o_data=0; hold register empty; frames_ok=0, frames_err=0; gap counter cleared.
- Output slot is one register. o_rdy = (!o_vld || i_rdy) && !flush_pending. Consumer back-pressure therefore stalls the receiver.
- One payload byte is always held back in a hold register (H), because the last byte cannot be marked until CHK arrives.
- Accepted payload byte with H full: H moves to the output slot (last=0), and the new byte goes into H.
- States and transitions, on each accepted byte:
  - HUNT0: byte==SYNC0 -> HUNT1.
  - HUNT1: byte==SYNC1 -> LEN; byte==SYNC0 -> stay in HUNT1; anything else -> HUNT0.
  - LEN: if 1 <= byte <= MAX_LEN, load the remaining-byte counter, set sum=byte and go to PAYLOAD. Otherwise frames_err++ and go to HUNT0, with no output.
  - PAYLOAD: sum += byte (8-bit wrap); counter decrements; go to CHK when the counter reaches 0 after this byte.
  - CHK: H moves to output with last=1 and err=(byte != sum); frames_ok++ or frames_err++; go to HUNT0.
- Parity fail: i_pc_pass=0 on any accepted byte in LEN, PAYLOAD or CHK aborts the frame. In HUNT0/HUNT1 such a byte is ignored and the parser returns to HUNT0.
- Timeout: gap counter reloads on every accepted byte and counts only in LEN, PAYLOAD or CHK. It expires after TIMEOUT_BYTES*10*(CLK_FREQ/TX_FREQ) cycles, which aborts the frame.
- Abort (parity or timeout):
  - frames_err++ and state -> HUNT0.
  - If H is full, H is emitted with last=1, err=1. If the output slot is busy, set flush_pending (o_rdy=0) until the slot frees, then emit.
  - If H is empty (abort before any payload), nothing is emitted.
- A byte that arrives in the same cycle the timeout expires is treated as arrived: no abort.
- A frame is counted exactly once. Counters hold at 16'hFFFF.
- o_data/o_last/o_err are stable while o_vld && !i_rdy.
- Latency: a non-final payload byte appears on o_data one cycle after the next payload byte is accepted. The final byte appears one cycle after CHK is accepted.
- Reset mid-frame discards H and the output slot immediately. Nothing is emitted.

Decomposition:
- Package uart_pkg holds:
  - state enum typedef {HUNT0, HUNT1, LEN, PAYLOAD, CHK};
  - function to compute the bit-period constant CLK_FREQ/TX_FREQ;
  - default sync byte constants.
- One natural sub-module, uart_gap_timer: loadable down-counter with an expire pulse, enabled only while mid-frame.
- Elaboration-time asserts: MAX_LEN in 1..255, TIMEOUT_BYTES >= 1, CLK_FREQ/TX_FREQ > 4.

Test Plan:
- Good frame: 55 AA 03 11 22 33 69, i_rdy=1 -> o_data 11, 22, 33; o_last only on 33; o_err=0; frames_ok=1, frames_err=0.
- Bad checksum: 55 AA 02 10 20 00 -> outputs 10, then 20 with last=1, err=1; frames_err=1.
- Resync and bad length: 00 55 55 AA 00 -> no output, frames_err=1. Then 55 AA 01 7E 7F -> 7E with last=1, err=0; frames_ok=1.
- Parity fail: 55 AA 04 01 02, then 03 with i_pc_pass=0 -> 01 (last=0), then 02 (last=1, err=1); frames_err=1; the next good frame parses normally.
- Timeout: 55 AA 04 A1 A2, then gap of TIMEOUT_BYTES*10*(CLK_FREQ/TX_FREQ) cycles -> A1, then A2 with last=1, err=1. A late A3 is ignored in HUNT0.
- Back-pressure: good frame with i_rdy held 0 for 20 cycles after the first o_vld -> o_rdy=0 while stalled; o_data held stable; no byte lost or duplicated; counters end at frames_ok=1.
